// File: rtl/tiny_evr_decoder.sv
// Receive-side event decoder: link qualification, event/distributed-bus extraction,
// seconds reconstruction and heartbeat supervision on the recovered RX word stream.
module tiny_evr_decoder #(
    parameter int unsigned LINK_GOOD_COUNT   = 1024,
    parameter int unsigned COMMA_TIMEOUT     = 65535,
    parameter int unsigned HEARTBEAT_TIMEOUT = 200000000
) (
    input  logic        evrRxClk,
    input  logic        reset_n,
    input  logic [15:0] rxData,
    input  logic [1:0]  rxIsK,
    input  logic [1:0]  rxDispErr,
    input  logic [1:0]  rxNotInTable,
    output logic        linkUp,
    output logic [7:0]  eventCode,
    output logic        eventStrobe,
    output logic [7:0]  distributedBus,
    output logic [31:0] seconds,
    output logic        secondsValid,
    output logic        ppsStrobe,
    output logic        heartbeatStrobe,
    output logic        heartbeatTimeout,
    output logic [15:0] errorCount
);

    localparam int unsigned GOOD_W  = $clog2(LINK_GOOD_COUNT + 1);
    localparam int unsigned COMMA_W = $clog2(COMMA_TIMEOUT + 1);
    localparam int unsigned HB_W    = $clog2(HEARTBEAT_TIMEOUT + 1);

    localparam logic [7:0] K28_5        = 8'hBC;
    localparam logic [7:0] EV_SHIFT0    = 8'h70;
    localparam logic [7:0] EV_SHIFT1    = 8'h71;
    localparam logic [7:0] EV_HEARTBEAT = 8'h7A;
    localparam logic [7:0] EV_PPS       = 8'h7D;
    localparam logic [5:0] BIT_CNT_MAX  = 6'd33;

    localparam logic [COMMA_W-1:0] COMMA_MAX = COMMA_W'(COMMA_TIMEOUT);
    localparam logic [HB_W-1:0]    HB_MAX    = HB_W'(HEARTBEAT_TIMEOUT);

    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } link_state_t;

    link_state_t        state, state_next;
    logic [GOOD_W-1:0]  good_cnt, good_cnt_next;
    logic [COMMA_W-1:0] comma_cnt;
    logic [HB_W-1:0]    hb_cnt, hb_cnt_next;
    logic [31:0]        shift_reg;
    logic [5:0]         bit_cnt;

    logic word_err_c, comma_c, comma_expire_c, go_down_c;
    logic ev_valid_c, bus_valid_c, shift_c, pps_c, hb_c;

    assign word_err_c     = |{rxDispErr, rxNotInTable};
    assign comma_c        = rxIsK[0] && (rxData[7:0] == K28_5);
    // Expiry fires on the COMMA_TIMEOUT-th consecutive comma-less word.
    assign comma_expire_c = !comma_c && (comma_cnt >= COMMA_W'(COMMA_TIMEOUT - 1));
    assign go_down_c      = (state == ST_UP) && (state_next == ST_DOWN);

    assign ev_valid_c  = (state == ST_UP) && !rxIsK[0] && !word_err_c && (rxData[7:0] != 8'h00);
    assign bus_valid_c = (state == ST_UP) && !rxIsK[1] && !word_err_c;
    assign shift_c     = ev_valid_c && ((rxData[7:0] == EV_SHIFT0) || (rxData[7:0] == EV_SHIFT1));
    assign pps_c       = ev_valid_c && (rxData[7:0] == EV_PPS);
    assign hb_c        = ev_valid_c && (rxData[7:0] == EV_HEARTBEAT);

    // Link FSM state register
    always_ff @(posedge evrRxClk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_DOWN;
            good_cnt <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_cnt_next;
        end
    end

    // Link FSM next state
    always_comb begin
        state_next    = state;
        good_cnt_next = good_cnt;
        case (state)
            ST_DOWN: begin
                if (word_err_c) begin
                    good_cnt_next = '0;
                end else if (good_cnt == GOOD_W'(LINK_GOOD_COUNT - 1)) begin
                    state_next    = ST_UP;
                    good_cnt_next = '0;
                end else begin
                    good_cnt_next = good_cnt + GOOD_W'(1);
                end
            end
            ST_UP: begin
                if (word_err_c || comma_expire_c) begin
                    state_next    = ST_DOWN;
                    good_cnt_next = '0;
                end
            end
            default: begin
                state_next    = ST_DOWN;
                good_cnt_next = '0;
            end
        endcase
    end

    // Heartbeat watchdog: pinned at saturation whenever the link is down
    always_comb begin
        hb_cnt_next = hb_cnt;
        if (state_next == ST_DOWN) begin
            hb_cnt_next = HB_MAX;
        end else if (hb_c) begin
            hb_cnt_next = '0;
        end else if (hb_cnt != HB_MAX) begin
            hb_cnt_next = hb_cnt + HB_W'(1);
        end
    end

    // Comma watchdog
    always_ff @(posedge evrRxClk or negedge reset_n) begin
        if (!reset_n) begin
            comma_cnt <= COMMA_MAX;
        end else if (comma_c) begin
            comma_cnt <= '0;
        end else if (comma_cnt != COMMA_MAX) begin
            comma_cnt <= comma_cnt + COMMA_W'(1);
        end
    end

    // Link status, event and bus outputs
    always_ff @(posedge evrRxClk or negedge reset_n) begin
        if (!reset_n) begin
            linkUp           <= 1'b0;
            eventCode        <= 8'h00;
            eventStrobe      <= 1'b0;
            ppsStrobe        <= 1'b0;
            heartbeatStrobe  <= 1'b0;
            distributedBus   <= 8'h00;
            hb_cnt           <= HB_MAX;
            heartbeatTimeout <= 1'b1;
            errorCount       <= 16'h0000;
        end else begin
            linkUp           <= (state_next == ST_UP);
            eventStrobe      <= ev_valid_c;
            ppsStrobe        <= pps_c;
            heartbeatStrobe  <= hb_c;
            hb_cnt           <= hb_cnt_next;
            heartbeatTimeout <= (hb_cnt_next == HB_MAX);
            if (ev_valid_c) begin
                eventCode <= rxData[7:0];
            end
            if (go_down_c) begin
                distributedBus <= 8'h00;
            end else if (bus_valid_c) begin
                distributedBus <= rxData[15:8];
            end
            if (word_err_c && (errorCount != 16'hFFFF)) begin
                errorCount <= errorCount + 16'd1;
            end
        end
    end

    // Seconds reconstruction; bit 0 of 0x70/0x71 is the shifted-in bit
    always_ff @(posedge evrRxClk or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg    <= '0;
            bit_cnt      <= '0;
            seconds      <= '0;
            secondsValid <= 1'b0;
        end else begin
            if (shift_c) begin
                shift_reg <= {shift_reg[30:0], rxData[0]};
            end
            if (pps_c) begin
                seconds <= shift_reg;
            end
            if (go_down_c) begin
                bit_cnt      <= '0;
                secondsValid <= 1'b0;
            end else if (pps_c) begin
                bit_cnt      <= '0;
                secondsValid <= (bit_cnt == 6'd32);
            end else if (shift_c && (bit_cnt != BIT_CNT_MAX)) begin
                bit_cnt <= bit_cnt + 6'd1;
            end
        end
    end

endmodule
